mux2_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8-bit output channel between two valid/ready requester streams, A and B.
- Drives the select of the 2-to-1 data path and registers the chosen beat into a single output stage.
- Supports burst locking: a granted requester keeps the channel until it sends its last beat or reaches the burst cap.
- Sits between two producers and one downstream consumer in the byte-stream datapath.

---
 rtl/mux2_arb_pkg.sv | 25 ++
 rtl/rr_pick2.sv | 31 +++
 rtl/mux2_stream_arbiter.sv | 154 +++++++++++++++
 tb/tb_mux2_stream_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : mux2_arb_pkg                                                     |
// | Brief   : Shared types and limits for the two-stream round-robin arbiter.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mux2_arb_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } arb_state_e;

    localparam int MAX_BURST_LIMIT = 255;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// +----------------------------------------------------------------------------+
// | Module  : rr_pick2                                                         |
// | Brief   : Combinational two-way round-robin pick, no state of its own.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick2
    import mux2_arb_pkg::*;
(
    input  logic i_a_valid,
    input  logic i_b_valid,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_any_valid
);

    always_comb begin
        o_any_valid = i_a_valid || i_b_valid;
        o_grant     = SRC_A;
        if (i_a_valid && i_b_valid) begin
            // Contested: the side that did not win last time goes first.
            o_grant = (i_last_grant == SRC_B) ? SRC_A : SRC_B;
        end else if (i_b_valid) begin
            o_grant = SRC_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux2_stream_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : mux2_stream_arbiter                                              |
// | Brief   : Burst-locking round-robin arbiter of two streams onto one        |
// |           registered output stage.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mux2_stream_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    output logic             sel
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CW-1:0]    r_beat_cnt;
    logic [CW-1:0]    w_beat_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic             r_last_grant;
    logic             w_last_grant_nxt;
    logic             r_sel;

    logic             w_pick_grant;
    logic             w_any_valid;
    logic             w_grant;
    logic             w_grant_act;
    logic             w_load_en;
    logic             w_in_valid;
    logic             w_in_last;
    logic [WIDTH-1:0] w_in_data;
    logic             w_xfer;
    logic             w_cap;
    logic             w_release;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_src;

    rr_pick2 u_rr_pick2 (
        .i_a_valid    (a_valid),
        .i_b_valid    (b_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_grant),
        .o_any_valid  (w_any_valid)
    );

    // While locked the other requester is ignored even if it is valid.
    always_comb begin
        w_grant     = w_pick_grant;
        w_grant_act = w_any_valid;
        case (r_state)
            ST_LOCK_A: begin
                w_grant     = SRC_A;
                w_grant_act = 1'b1;
            end
            ST_LOCK_B: begin
                w_grant     = SRC_B;
                w_grant_act = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_load_en  = !r_out_valid || out_ready;
    assign a_ready    = w_load_en && w_grant_act && (w_grant == SRC_A);
    assign b_ready    = w_load_en && w_grant_act && (w_grant == SRC_B);
    assign sel        = w_grant_act ? w_grant : r_sel;

    assign w_in_valid = w_grant ? b_valid : a_valid;
    assign w_in_last  = w_grant ? b_last  : a_last;
    assign w_in_data  = sel ? b_data : a_data;

    assign w_xfer     = w_grant_act && w_load_en && w_in_valid;
    assign w_cnt_inc  = r_beat_cnt + CW'(1);
    assign w_cap      = (w_cnt_inc == CW'(MAX_BURST));
    assign w_release  = w_xfer && (w_in_last || w_cap);

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_last_grant_nxt = r_last_grant;
        if (w_xfer) begin
            if (w_release) begin
                w_state_nxt      = ST_IDLE;
                w_beat_cnt_nxt   = '0;
                w_last_grant_nxt = w_grant;
            end else begin
                w_state_nxt    = w_grant ? ST_LOCK_B : ST_LOCK_A;
                w_beat_cnt_nxt = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_last_grant <= SRC_B;
            r_sel        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_sel        <= sel;
        end
    end

    // A cap-forced release is flagged downstream as a burst end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_in_data;
            r_out_last  <= w_in_last || w_cap;
            r_out_src   <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

`default_nettype wire

// File: tb/tb_mux2_stream_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_mux2_stream_arbiter                                           |
// | Brief   : Directed scoreboard bench for mux2_stream_arbiter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mux2_stream_arbiter;

    typedef struct packed {
        logic       src;
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic       clk;
    logic       reset;
    logic       a_valid, a_ready, a_last;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_last;
    logic [7:0] b_data;
    logic       out_valid, out_ready, out_last, out_src, sel;
    logic [7:0] out_data;

    beat_t      q_exp[$];
    int         n_checks = 0;
    int         n_errors = 0;

    mux2_stream_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .a_last    (a_last),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .b_last    (b_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic src, input logic last, input logic [7:0] data);
        q_exp.push_back('{src: src, last: last, data: data});
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_last = 1'b0; a_data = 8'h00;
        b_valid = 1'b0; b_last = 1'b0; b_data = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Output beats are compared on the falling edge, where they are stable.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL out_unexpected: observed=%0h expected=none", out_data);
            end else begin
                beat_t e;
                e = q_exp.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_src",  out_src,  e.src);
                chk("out_last", out_last, e.last);
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        do_reset();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_out_src",   out_src,   0);
        chk("rst_sel",       sel,       0);
        chk("rst_state",     dut.r_state, 0);
        chk("rst_beat_cnt",  dut.r_beat_cnt, 0);

        // Single beat from A, same-cycle ready, one-cycle latency
        a_valid = 1'b1; a_data = 8'h11; a_last = 1'b1;
        #1;
        chk("t1_a_ready", a_ready, 1);
        chk("t1_b_ready", b_ready, 0);
        push(1'b0, 1'b1, 8'h11);
        tick();
        idle_inputs();
        chk("t1_out_valid", out_valid, 1);
        tick();
        tick();

        // Per-beat round robin, A first after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_last = 1'b1; a_data = 8'hA0 + 8'((i + 1) / 2);
            b_valid = 1'b1; b_last = 1'b1; b_data = 8'hB0 + 8'(i / 2);
            #1;
            chk("t2_a_ready", a_ready, (i % 2 == 0));
            chk("t2_b_ready", b_ready, (i % 2 == 1));
            chk("t2_sel",     sel,     (i % 2 == 1));
            if (i % 2 == 0) push(1'b0, 1'b1, 8'hA0 + 8'(i / 2));
            else            push(1'b1, 1'b1, 8'hB0 + 8'(i / 2));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // A burst of three holds off a waiting B
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'hC1;
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1; a_data = 8'(i + 1); a_last = (i == 2);
            #1;
            chk("t3_a_ready", a_ready, 1);
            chk("t3_b_ready", b_ready, 0);
            push(1'b0, (i == 2), 8'(i + 1));
            tick();
        end
        a_valid = 1'b0;
        #1;
        chk("t3_b_after", b_ready, 1);
        push(1'b1, 1'b1, 8'hC1);
        tick();
        idle_inputs();
        tick();
        tick();

        // Burst cap forces release after four beats
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'hD1;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1; a_last = 1'b0; a_data = 8'h10 + 8'(i);
            #1;
            chk("t4_a_ready", a_ready, 1);
            chk("t4_b_ready", b_ready, 0);
            push(1'b0, (i == 3), 8'h10 + 8'(i));
            tick();
        end
        a_data = 8'h14;
        #1;
        chk("t4_cap_a_ready", a_ready, 0);
        chk("t4_cap_b_ready", b_ready, 1);
        push(1'b1, 1'b1, 8'hD1);
        tick();
        b_valid = 1'b0;
        for (int i = 4; i < 6; i++) begin
            a_data = 8'h10 + 8'(i); a_last = (i == 5);
            #1;
            chk("t4_tail_a_ready", a_ready, 1);
            push(1'b0, (i == 5), 8'h10 + 8'(i));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Backpressure stalls everything and loses nothing
        a_valid = 1'b1; a_data = 8'h31; a_last = 1'b0;
        push(1'b0, 1'b0, 8'h31);
        tick();
        out_ready = 1'b0;
        a_data = 8'h32; a_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_out_valid", out_valid, 1);
            chk("t5_out_data",  out_data,  8'h31);
            chk("t5_a_ready",   a_ready,   0);
            chk("t5_b_ready",   b_ready,   0);
            chk("t5_beat_cnt",  dut.r_beat_cnt, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t5_resume_a_ready", a_ready, 1);
        push(1'b0, 1'b1, 8'h32);
        tick();
        idle_inputs();
        tick();
        tick();

        // Reset in the middle of a locked A burst
        a_valid = 1'b1; a_data = 8'h41; a_last = 1'b0;
        push(1'b0, 1'b0, 8'h41);
        tick();
        a_data = 8'h42;
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'h61;
        #1;
        chk("t6_lock_b_ready", b_ready, 0);
        chk("t6_lock_a_ready", a_ready, 1);
        tick();
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_state",     dut.r_state, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        a_data = 8'h51; a_last = 1'b1;
        #1;
        chk("t6_post_a_ready", a_ready, 1);
        chk("t6_post_b_ready", b_ready, 0);
        push(1'b0, 1'b1, 8'h51);
        tick();
        a_valid = 1'b0;
        #1;
        chk("t6_post_b_next", b_ready, 1);
        push(1'b1, 1'b1, 8'h61);
        tick();
        idle_inputs();
        tick();
        tick();

        chk("scoreboard_empty", q_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
